// File: rtl/scr1_test_exit_monitor.sv
// scr1_test_exit_monitor: sequences one test run (core reset, run, exit/timeout verdict) and keeps saturating pass/total stats.
module scr1_test_exit_monitor #(
  parameter int NUM_HARTS = 1,
  parameter int XLEN = 32,
  parameter logic [XLEN-1:0] EXIT_ADDR = 'h0000_00F8,
  parameter int RST_CYCLES = 4,
  parameter int TMO_W = 24,
  parameter int CNT_W = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      clr_stats,
  input  logic [TMO_W-1:0]          tmo_limit,
  input  logic [NUM_HARTS-1:0]      pc_vld,
  input  logic [NUM_HARTS*XLEN-1:0] pc,
  input  logic [NUM_HARTS*XLEN-1:0] a0,
  output logic                      core_rst,
  output logic                      busy,
  output logic                      done,
  output logic                      pass,
  output logic                      timeout,
  output logic [NUM_HARTS-1:0]      hart_done,
  output logic [NUM_HARTS-1:0]      hart_pass,
  output logic [CNT_W-1:0]          tests_total,
  output logic [CNT_W-1:0]          tests_passed
);
  typedef enum logic [1:0] {IDLE, RESET, RUN, DONE} state_t;
  localparam int RW = RST_CYCLES > 1 ? $clog2(RST_CYCLES) : 1;
  localparam logic [RW-1:0] RST_LAST = RW'(RST_CYCLES - 1);
  state_t state;
  logic [RW-1:0] rst_cnt;
  logic [TMO_W-1:0] tmo_cnt;
  logic [NUM_HARTS-1:0] exit_v, a0_zero, hd_nxt, hp_nxt;
  logic complete, tmo_hit, fin, pass_nxt;
  for (genvar g = 0; g < NUM_HARTS; g++) begin : g_hart
    assign exit_v[g] = state == RUN && pc_vld[g] && pc[g*XLEN +: XLEN] == EXIT_ADDR && !hart_done[g];
    assign a0_zero[g] = a0[g*XLEN +: XLEN] == '0;
  end
  assign hd_nxt = hart_done | exit_v;
  assign hp_nxt = hart_pass | (exit_v & a0_zero);
  assign complete = &hd_nxt;
  assign tmo_hit = tmo_limit != '0 && tmo_cnt == tmo_limit - TMO_W'(1);
  assign fin = state == RUN && (complete || tmo_hit);
  // exit completion beats a coincident timeout, so the verdict only needs complete
  assign pass_nxt = complete && &hp_nxt;
  assign core_rst = state == RESET;
  assign busy = state != IDLE;
  assign done = state == DONE;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      rst_cnt <= '0;
      tmo_cnt <= '0;
      hart_done <= '0;
      hart_pass <= '0;
      pass <= 1'b0;
      timeout <= 1'b0;
      tests_total <= '0;
      tests_passed <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          state <= RESET;
          rst_cnt <= '0;
          tmo_cnt <= '0;
          hart_done <= '0;
          hart_pass <= '0;
          pass <= 1'b0;
          timeout <= 1'b0;
        end
        RESET: begin
          rst_cnt <= rst_cnt + 1'b1;
          if (rst_cnt == RST_LAST) state <= RUN;
        end
        RUN: begin
          tmo_cnt <= tmo_cnt + 1'b1;
          hart_done <= hd_nxt;
          hart_pass <= hp_nxt;
          if (fin) begin
            state <= DONE;
            pass <= pass_nxt;
            timeout <= !complete;
          end
        end
        default: state <= IDLE;
      endcase
      if (clr_stats) begin
        tests_total <= '0;
        tests_passed <= '0;
      end else if (fin) begin
        tests_total <= tests_total + CNT_W'(tests_total != '1);
        tests_passed <= tests_passed + CNT_W'(pass_nxt && tests_passed != '1);
      end
    end
  end
endmodule

// File: tb/tb_scr1_test_exit_monitor.sv
// tb_scr1_test_exit_monitor: directed checks on a 1-hart and a 4-hart/2-bit-counter instance.
module tb_scr1_test_exit_monitor;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  logic a_start = 0, a_clr = 0, a_vld = 0;
  logic [23:0] a_tmo = 0;
  logic [31:0] a_pc = 0, a_a0 = 0;
  logic a_core_rst, a_busy, a_done, a_pass, a_timeout;
  logic [0:0] a_hd, a_hp;
  logic [15:0] a_total, a_passed;
  logic b_start = 0, b_clr = 0;
  logic [3:0] b_vld = 0;
  logic [23:0] b_tmo = 0;
  logic [127:0] b_pc = 0, b_a0 = 0;
  logic b_core_rst, b_busy, b_done, b_pass, b_timeout;
  logic [3:0] b_hd, b_hp;
  logic [1:0] b_total, b_passed;
  int n_chk = 0, n_fail = 0;
  scr1_test_exit_monitor u1 (
    .clk(clk), .rst(rst), .start(a_start), .clr_stats(a_clr), .tmo_limit(a_tmo),
    .pc_vld(a_vld), .pc(a_pc), .a0(a_a0), .core_rst(a_core_rst), .busy(a_busy),
    .done(a_done), .pass(a_pass), .timeout(a_timeout), .hart_done(a_hd),
    .hart_pass(a_hp), .tests_total(a_total), .tests_passed(a_passed));
  scr1_test_exit_monitor #(.NUM_HARTS(4), .CNT_W(2)) u4 (
    .clk(clk), .rst(rst), .start(b_start), .clr_stats(b_clr), .tmo_limit(b_tmo),
    .pc_vld(b_vld), .pc(b_pc), .a0(b_a0), .core_rst(b_core_rst), .busy(b_busy),
    .done(b_done), .pass(b_pass), .timeout(b_timeout), .hart_done(b_hd),
    .hart_pass(b_hp), .tests_total(b_total), .tests_passed(b_passed));
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic run_a();
    a_start = 1;
    tick();
    a_start = 0;
    repeat (4) tick();
  endtask
  task automatic run_b();
    b_start = 1;
    tick();
    b_start = 0;
    repeat (4) tick();
  endtask
  initial begin
    b_pc = {4{32'h0000_00F8}};
    repeat (2) tick();
    check("rst_core_rst", a_core_rst, 0);
    check("rst_busy", a_busy, 0);
    check("rst_done", a_done, 0);
    check("rst_pass", a_pass, 0);
    check("rst_hd", b_hd, 0);
    check("rst_total", a_total, 0);
    rst = 0;
    // reset mid-run on the 4-hart instance, with a stray start during RUN
    run_b();
    b_vld = 4'b0010;
    tick();
    b_vld = 0;
    check("mid_hd", b_hd, 4'h2);
    repeat (4) tick();
    b_start = 1;
    tick();
    b_start = 0;
    check("start_ign_busy", b_busy, 1);
    check("start_ign_core_rst", b_core_rst, 0);
    repeat (4) tick();
    rst = 1;
    tick();
    rst = 0;
    check("mrst_busy", b_busy, 0);
    check("mrst_core_rst", b_core_rst, 0);
    check("mrst_done", b_done, 0);
    check("mrst_pass", b_pass, 0);
    check("mrst_timeout", b_timeout, 0);
    check("mrst_hd", b_hd, 0);
    check("mrst_hp", b_hp, 0);
    check("mrst_total", b_total, 0);
    check("mrst_passed", b_passed, 0);
    tick();
    check("mrst_stay_idle", b_busy, 0);
    // test 1: passing run, reset pulse timing
    a_start = 1;
    tick();
    a_start = 0;
    for (int i = 1; i <= 4; i++) begin
      check($sformatf("t1_core_rst_c%0d", i), a_core_rst, 1);
      check($sformatf("t1_busy_c%0d", i), a_busy, 1);
      tick();
    end
    check("t1_core_rst_run", a_core_rst, 0);
    check("t1_busy_run", a_busy, 1);
    a_vld = 1; a_pc = 32'hF4; a_a0 = 0;
    tick();
    check("t1_non_exit", a_done, 0);
    a_pc = 32'hF8;
    tick();
    a_vld = 0;
    check("t1_done", a_done, 1);
    check("t1_pass", a_pass, 1);
    check("t1_timeout", a_timeout, 0);
    check("t1_hd", a_hd, 1);
    check("t1_total", a_total, 1);
    check("t1_passed", a_passed, 1);
    tick();
    check("t1_done_off", a_done, 0);
    check("t1_busy_off", a_busy, 0);
    check("t1_pass_held", a_pass, 1);
    // test 2: failing a0, later exit ignored
    run_a();
    a_vld = 1; a_pc = 32'hF8; a_a0 = 3;
    tick();
    a_a0 = 0;
    check("t2_done", a_done, 1);
    check("t2_pass", a_pass, 0);
    check("t2_timeout", a_timeout, 0);
    check("t2_total", a_total, 2);
    check("t2_passed", a_passed, 1);
    tick();
    a_vld = 0;
    check("t2_hp_kept", a_hp, 0);
    check("t2_pass_kept", a_pass, 0);
    check("t2_total_kept", a_total, 2);
    // test 3: timeout of 100, with exit PCs during RESET ignored
    a_tmo = 100;
    a_start = 1;
    tick();
    a_start = 0;
    a_vld = 1; a_pc = 32'hF8;
    repeat (4) tick();
    a_vld = 0;
    check("t3_reset_ign", a_hd, 0);
    repeat (99) tick();
    check("t3_not_yet", a_done, 0);
    tick();
    check("t3_done", a_done, 1);
    check("t3_timeout", a_timeout, 1);
    check("t3_pass", a_pass, 0);
    check("t3_total", a_total, 3);
    check("t3_passed", a_passed, 1);
    a_tmo = 0;
    tick();
    // test 4: four harts, staggered exits, timeout on the final exit cycle
    b_tmo = 3;
    run_b();
    b_vld = 4'b0101; b_a0 = '0;
    tick();
    check("t4_hd_a", b_hd, 4'h5);
    check("t4_hp_a", b_hp, 4'h5);
    check("t4_done_a", b_done, 0);
    b_vld = 4'b0001; b_a0[31:0] = 5;
    tick();
    check("t4_hp_first_only", b_hp, 4'h5);
    b_vld = 4'b1010; b_a0 = '0; b_a0[127:96] = 1;
    tick();
    b_vld = 0; b_a0 = '0; b_tmo = 0;
    check("t4_done", b_done, 1);
    check("t4_hd", b_hd, 4'hF);
    check("t4_hp", b_hp, 4'h7);
    check("t4_pass", b_pass, 0);
    check("t4_timeout", b_timeout, 0);
    check("t4_total", b_total, 1);
    check("t4_passed", b_passed, 0);
    tick();
    // saturation: five passing runs
    for (int r = 0; r < 5; r++) begin
      run_b();
      b_vld = 4'hF;
      tick();
      b_vld = 0;
      check($sformatf("sat_pass_r%0d", r), b_pass, 1);
      tick();
    end
    check("sat_total", b_total, 3);
    check("sat_passed", b_passed, 3);
    // clear coincident with DONE entry
    run_b();
    b_vld = 4'hF; b_clr = 1;
    tick();
    b_vld = 0; b_clr = 0;
    check("clr_done", b_done, 1);
    check("clr_total", b_total, 0);
    check("clr_passed", b_passed, 0);
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
